// File: rtl/burst_mem_responder.sv
// Burst memory responder: accepts line read/write requests and serves each as a
// 4-beat x 64-bit burst after a fixed latency, backed by a LINES x 256-bit store.
// Optional protocol checker is built when BURST_MEM_PROTO_CHECK_EN is defined.
// Timing: the accept edge counts as the first latency edge, so WAIT lasts
// LATENCY-1 cycles (skipped for LATENCY=1) and accept edges of back-to-back
// requests are LATENCY+5 cycles apart.
module burst_mem_responder #(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned LINES   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned WORDS  = LINES * 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                is_read_q, is_read_d;
    logic [63:0]         mem_q [WORDS];

    // Next-state: latch request in IDLE, count latency, step through 4 beats, one DONE cycle.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        idx_d     = idx_q;
        is_read_d = is_read_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d     = mem_address[5 +: IDX_W];
                    is_read_d = mem_read;
                    beat_d    = '0;
                    if (LATENCY <= 1) begin
                        state_d = BURST;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = BURST;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            BURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            idx_q     <= '0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            idx_q     <= idx_d;
            is_read_q <= is_read_d;
        end
    end

    // Line storage: write beats land at the end of each beat cycle; reset abandons the rest.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == BURST) && !is_read_q) begin
            mem_q[{idx_q, beat_q}] <= mem_wdata;
        end
    end

    // Beat strobe and read data, zero outside read beats.
    assign mem_resp  = (state_q == BURST);
    assign mem_rdata = (mem_resp && is_read_q) ? mem_q[{idx_q, beat_q}] : '0;

`ifdef BURST_MEM_PROTO_CHECK_EN
    logic [31:0] addr_q;
    logic        proto_err_q, proto_err_d;
    logic        active_c;
    logic        req_held_c;

    // Address as seen at the accept edge, for change detection during the transfer.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            addr_q <= mem_address;
        end
    end

    // Sticky violation detect: both requests high, or request/address not held while busy.
    always_comb begin
        active_c    = (state_q == WAIT) || (state_q == BURST);
        req_held_c  = is_read_q ? mem_read : mem_write;
        proto_err_d = proto_err_q
                    | (mem_read & mem_write)
                    | (active_c & (~req_held_c | (mem_address != addr_q)));
    end

    // Violation flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    logic addr_unused;

    // Only the index bits of the address matter without the checker.
    assign addr_unused = ^mem_address;
    assign proto_err   = 1'b0;
`endif

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 8, meaning the number of cycles from request acceptance to the first response beat (legal range 1..255).
REQ-002 SHALL provide parameter LINES, default 64, meaning the number of 256-bit lines stored (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_read  input  1  initiator line-read request, held until the burst completes.
REQ-006 SHALL have port mem_write  input  1  initiator line-write request, held until the burst completes.
REQ-007 SHALL have port mem_address  input  32  line address; bits [4:0] ignored.
REQ-008 SHALL have port mem_wdata  input  64  write beat data.
REQ-009 SHALL have port mem_rdata  output  64  read beat data.
REQ-010 SHALL have port mem_resp  output  1  beat-valid strobe.
REQ-011 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL implement states IDLE, WAIT, BURST and DONE.
REQ-013 Line index SHALL be mem_address[5 +: log2(LINES)]; higher address bits SHALL be ignored, so addresses alias modulo LINES.
REQ-014 In IDLE, if mem_read or mem_write is high at a rising edge, the responder SHALL latch the index and the operation and go to WAIT; if both are high, read SHALL win.
REQ-015 WAIT SHALL count so that the first mem_resp is high in the cycle beginning LATENCY edges after the accept edge; LATENCY=1 gives BURST on the next cycle.
REQ-016 BURST SHALL assert mem_resp for exactly 4 consecutive cycles (beats 0..3), then go to DONE.
REQ-017 Beat k SHALL map to line bits [64k+63:64k], with beat 0 first.
REQ-018 On a read, mem_rdata SHALL present beat k of the latched line combinationally while mem_resp is high, and SHALL be 0 otherwise.
REQ-019 On a write, mem_wdata SHALL be stored into beat k of the latched line at the edge ending each mem_resp cycle.
REQ-020 DONE SHALL last exactly one cycle with mem_resp low, then go to IDLE; the next request SHALL NOT be accepted before IDLE.
REQ-021 After acceptance, mem_address and operation changes SHALL be ignored until IDLE.
REQ-022 If the request drops before beat 3, the burst SHALL still complete all 4 beats, and write beats SHALL still be stored.
REQ-023 A read issued after a write to the same index SHALL return the written data.
REQ-024 Back-to-back requests SHALL see a minimum of LATENCY+5 cycles between accept edges.

Reset
REQ-025 When rst is high at an edge, the responder SHALL go to IDLE, clear the latency counter, beat counter and proto_err, and drive mem_resp=0 and mem_rdata=0 the following cycle.
REQ-026 Reset SHALL NOT alter line storage; an in-flight write SHALL keep the beats already stored and abandon the remaining beats.
REQ-027 A request held high across reset release SHALL be accepted at the first edge with rst low.

Configuration
REQ-028 Macro BURST_MEM_PROTO_CHECK_EN SHALL control the protocol checker.
REQ-029 When BURST_MEM_PROTO_CHECK_EN is defined, proto_err SHALL set, and stay set until reset, on any of these events at an edge:
- mem_read and mem_write both high;
- a request deasserted while in WAIT or BURST;
- mem_address changed while in WAIT or BURST.
REQ-030 When BURST_MEM_PROTO_CHECK_EN is undefined, proto_err SHALL be constant 0 and no checker logic SHALL be built.

Verification
REQ-031 Write index 3 (addr 0x60), beats 0x11..1,0x22..2,0x33..3,0x44..4, LATENCY=8 -> mem_resp high on cycles 8..11 after accept, then low for 1 cycle.
REQ-032 Read addr 0x60 after the REQ-031 write -> mem_rdata = 0x11..1,0x22..2,0x33..3,0x44..4 on 4 consecutive resp cycles, and 0 otherwise.
REQ-033 Write addr 0x60+64*32, then read addr 0x60 -> the read returns the aliased new data.
REQ-034 mem_read and mem_write both high at addr 0x80 -> a read burst is served; proto_err=1 with the macro defined, 0 without.
REQ-035 rst pulsed during beat 2 of a write -> mem_resp=0 next cycle; a later read returns new beats 0..1 and old beats 2..3.
REQ-036 LATENCY=1 with back-to-back reads held high -> accept edges exactly 6 cycles apart.
